// File: rtl/tournament_choice_ctrl_if.sv
// Request/resolve bundle for the tournament chooser controller.
// The slave side is the controller; the master side drives requests and resolutions.
interface tournament_choice_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             pred_v_i;
  logic [IDX_W-1:0] pred_idx_i;
  logic             global_pred_i;
  logic             local_pred_i;
  logic             pred_ready_o;
  logic             choice_v_o;
  logic [1:0]       choice_o;
  logic             resolve_v_i;
  logic             taken_i;
  logic             init_done_o;
  logic [CNT_W-1:0] fifo_count_o;
  logic             resolve_err_o;

  modport slave (
    input  pred_v_i, pred_idx_i, global_pred_i, local_pred_i, resolve_v_i, taken_i,
    output pred_ready_o, choice_v_o, choice_o, init_done_o, fifo_count_o, resolve_err_o
  );

  modport master (
    output pred_v_i, pred_idx_i, global_pred_i, local_pred_i, resolve_v_i, taken_i,
    input  pred_ready_o, choice_v_o, choice_o, init_done_o, fifo_count_o, resolve_err_o
  );
endinterface

// File: rtl/tournament_choice_ctrl.sv
// Chooser table owner for a tournament predictor: initialises the table after reset,
// serves 2-bit choices, and retrains counters in order as in-flight branches resolve.
module tournament_choice_ctrl #(
  parameter int         IDX_W    = 4,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input logic clk,
  input logic reset,
  tournament_choice_ctrl_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] init_ptr;
  logic [1:0]       chooser [ENTRIES];

  logic [IDX_W-1:0] fifo_idx [DEPTH];
  logic             fifo_g   [DEPTH];
  logic             fifo_l   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             is_ready;
  logic             pred_ready;
  logic             accept;
  logic             resolve_ok;
  logic [IDX_W-1:0] head_idx;
  logic             head_g;
  logic             head_l;
  logic [1:0]       head_val;
  logic [1:0]       upd_val;

  logic             choice_v;
  logic [1:0]       choice;
  logic             resolve_err;

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign is_ready   = (state == ST_READY);
  assign pred_ready = is_ready && (count != CNT_W'(DEPTH));
  assign accept     = bus.pred_v_i && pred_ready;
  assign resolve_ok = bus.resolve_v_i && is_ready && (count != '0);

  assign head_idx = fifo_idx[rd_ptr];
  assign head_g   = fifo_g[rd_ptr];
  assign head_l   = fifo_l[rd_ptr];
  assign head_val = chooser[head_idx];

  // Train toward whichever component alone was right; ties leave the counter alone.
  always_comb begin
    upd_val = head_val;
    if ((head_g == bus.taken_i) && (head_l != bus.taken_i) && (head_val != 2'd3))
      upd_val = head_val + 2'd1;
    else if ((head_l == bus.taken_i) && (head_g != bus.taken_i) && (head_val != 2'd0))
      upd_val = head_val - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else if (state == ST_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == {IDX_W{1'b1}})
        state <= ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      chooser[init_ptr] <= INIT_VAL;
    else if (resolve_ok)
      chooser[head_idx] <= upd_val;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_idx[wr_ptr] <= bus.pred_idx_i;
      fifo_g[wr_ptr]   <= bus.global_pred_i;
      fifo_l[wr_ptr]   <= bus.local_pred_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (resolve_ok)
        rd_ptr <= rd_ptr + 1'b1;
      if (accept && !resolve_ok)
        count <= count + 1'b1;
      else if (!accept && resolve_ok)
        count <= count - 1'b1;
    end
  end

  // The accept reads the table before any same-cycle resolve write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      choice_v    <= 1'b0;
      choice      <= 2'b00;
      resolve_err <= 1'b0;
    end else begin
      choice_v    <= accept;
      resolve_err <= bus.resolve_v_i && !resolve_ok;
      if (accept)
        choice <= chooser[bus.pred_idx_i];
    end
  end

  assign bus.pred_ready_o  = pred_ready;
  assign bus.choice_v_o    = choice_v;
  assign bus.choice_o      = choice;
  assign bus.init_done_o   = is_ready;
  assign bus.fifo_count_o  = count;
  assign bus.resolve_err_o = resolve_err;
endmodule

// File: tb/tb_tournament_choice_ctrl.sv
// Self-checking bench for tournament_choice_ctrl: directed scenarios plus randomized
// traffic, all checked against a queue-and-array model of the chooser.
module tb_tournament_choice_ctrl;
  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tournament_choice_ctrl_if #(.IDX_W(IDX_W), .DEPTH(DEPTH)) bus ();

  tournament_choice_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH), .INIT_VAL(2'b01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    bit g;
    bit l;
  } entry_t;

  int     tests_run = 0;
  int     tests_failed = 0;
  int     m_tbl [ENTRIES];
  entry_t q [$];
  bit     m_ready;
  int     m_init;
  int     exp_choice;
  bit     exp_choice_v;
  bit     exp_err;
  int     exp_count;

  task automatic model_reset();
    m_ready = 0;
    m_init = 0;
    q.delete();
    exp_choice = 0;
    exp_choice_v = 0;
    exp_err = 0;
    exp_count = 0;
  endtask

  // One clock of the reference: read-before-write, in-order retire, saturating training.
  task automatic model_step(input bit pv, input int idx, input bit g, input bit l,
                            input bit rv, input bit t);
    bit     acc;
    bit     rok;
    entry_t h;
    acc = pv && m_ready && (q.size() < DEPTH);
    rok = rv && m_ready && (q.size() > 0);
    exp_choice_v = acc;
    if (acc) exp_choice = m_tbl[idx];
    exp_err = rv && !rok;
    if (!m_ready) begin
      m_tbl[m_init] = 1;
      m_init++;
      if (m_init == ENTRIES) m_ready = 1;
    end else if (rok) begin
      h = q.pop_front();
      if (h.g == t && h.l != t && m_tbl[h.idx] < 3) m_tbl[h.idx]++;
      else if (h.l == t && h.g != t && m_tbl[h.idx] > 0) m_tbl[h.idx]--;
    end
    if (acc) q.push_back('{idx: idx, g: g, l: l});
    exp_count = q.size();
  endtask

  task automatic drive_cycle(input bit pv, input int idx, input bit g, input bit l,
                             input bit rv, input bit t);
    bus.pred_v_i      = pv;
    bus.pred_idx_i    = idx[IDX_W-1:0];
    bus.global_pred_i = g;
    bus.local_pred_i  = l;
    bus.resolve_v_i   = rv;
    bus.taken_i       = t;
    model_step(pv, idx, g, l, rv, t);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 16) begin
      drive_cycle(0, 0, 0, 0, 1, 0);
      guard++;
    end
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    tests_run += 6;
    if (bus.pred_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %0d expected 0", bus.pred_ready_o); end
    if (bus.choice_v_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_choice_v: got %0d expected 0", bus.choice_v_o); end
    if (bus.choice_o !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_choice: got %0d expected 0", bus.choice_o); end
    if (bus.init_done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_init_done: got %0d expected 0", bus.init_done_o); end
    if (bus.fifo_count_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count_o); end
    if (bus.resolve_err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %0d expected 0", bus.resolve_err_o); end
    reset = 1'b0;
  endtask

  task automatic test_init_walk();
    for (int i = 0; i < ENTRIES; i++) begin
      tests_run++;
      if (bus.pred_ready_o !== 1'b0 || bus.init_done_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL init_cycle_%0d: got ready=%0d done=%0d expected 0/0", i, bus.pred_ready_o, bus.init_done_o);
      end
      drive_cycle(1, 5, 0, 0, 0, 0);
    end
    tests_run += 2;
    if (bus.init_done_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL init_done: got %0d expected 1", bus.init_done_o); end
    if (bus.pred_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL init_ready: got %0d expected 1", bus.pred_ready_o); end
    drive_cycle(1, 5, 0, 0, 0, 0);
    tests_run++;
    if (bus.choice_v_o !== 1'b1 || bus.choice_o !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL first_choice: got v=%0d val=%0d expected v=1 val=1", bus.choice_v_o, bus.choice_o);
    end
    drain();
  endtask

  task automatic test_increment_saturation();
    int exp_seq [4] = '{1, 2, 3, 3};
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1, 3, 1, 0, 0, 0);
      tests_run++;
      if (bus.choice_v_o !== 1'b1 || int'(bus.choice_o) !== exp_seq[k] || exp_choice !== exp_seq[k]) begin
        tests_failed++;
        $display("[TB] FAIL inc_read_%0d: got %0d expected %0d", k, bus.choice_o, exp_seq[k]);
      end
      drive_cycle(0, 0, 0, 0, 1, 1);
    end
  endtask

  task automatic test_decrement();
    int exp_seq [6] = '{3, 2, 1, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1, 3, k < 5, k == 4, 0, 0);
      tests_run++;
      if (int'(bus.choice_o) !== exp_seq[k] || exp_choice !== exp_seq[k]) begin
        tests_failed++;
        $display("[TB] FAIL dec_read_%0d: got %0d expected %0d", k, bus.choice_o, exp_seq[k]);
      end
      drive_cycle(0, 0, 0, 0, 1, k == 4);
    end
  endtask

  task automatic test_full_fifo();
    for (int k = 0; k < DEPTH; k++) drive_cycle(1, 8 + k, 0, 0, 0, 0);
    tests_run += 2;
    if (bus.fifo_count_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_count: got %0d expected 4", bus.fifo_count_o); end
    if (bus.pred_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_ready: got %0d expected 0", bus.pred_ready_o); end
    drive_cycle(1, 12, 0, 0, 1, 0);
    tests_run += 2;
    if (bus.choice_v_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_no_passthru: got %0d expected 0", bus.choice_v_o); end
    if (bus.fifo_count_o !== 3'd3) begin tests_failed++; $display("[TB] FAIL full_pop_count: got %0d expected 3", bus.fifo_count_o); end
    drive_cycle(1, 12, 0, 0, 0, 0);
    drive_cycle(1, 13, 0, 0, 1, 0);
    tests_run += 2;
    if (bus.choice_v_o !== 1'b0 && exp_count != 4) begin tests_failed++; $display("[TB] FAIL full_refill: got %0d expected 0", bus.choice_v_o); end
    if (int'(bus.fifo_count_o) !== exp_count) begin tests_failed++; $display("[TB] FAIL full_steady_count: got %0d expected %0d", bus.fifo_count_o, exp_count); end
    drain();
    tests_run++;
    if (bus.fifo_count_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL full_drained: got %0d expected 0", bus.fifo_count_o); end
  endtask

  task automatic test_same_index();
    drive_cycle(1, 7, 1, 0, 0, 0);
    drive_cycle(1, 7, 1, 0, 1, 1);
    tests_run += 2;
    if (bus.choice_o !== 2'd1) begin tests_failed++; $display("[TB] FAIL same_idx_pre_update: got %0d expected 1", bus.choice_o); end
    if (bus.fifo_count_o !== 3'd1) begin tests_failed++; $display("[TB] FAIL same_idx_count: got %0d expected 1", bus.fifo_count_o); end
    drive_cycle(1, 7, 0, 0, 0, 0);
    tests_run++;
    if (bus.choice_o !== 2'd2) begin tests_failed++; $display("[TB] FAIL same_idx_followup: got %0d expected 2", bus.choice_o); end
    drain();
  endtask

  task automatic test_resolve_error();
    drive_cycle(0, 0, 0, 0, 1, 1);
    tests_run += 2;
    if (bus.resolve_err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_pulse: got %0d expected 1", bus.resolve_err_o); end
    if (bus.fifo_count_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL err_count: got %0d expected 0", bus.fifo_count_o); end
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.resolve_err_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_one_cycle: got %0d expected 0", bus.resolve_err_o); end
    drive_cycle(1, 7, 0, 0, 0, 0);
    tests_run++;
    if (int'(bus.choice_o) !== exp_choice) begin tests_failed++; $display("[TB] FAIL err_table_unchanged: got %0d expected %0d", bus.choice_o, exp_choice); end
    drain();
  endtask

  task automatic test_random();
    bit pv, g, l, rv, t;
    int idx;
    for (int c = 0; c < 400; c++) begin
      tests_run++;
      if (bus.pred_ready_o !== (m_ready && q.size() < DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL rand_ready_%0d: got %0d expected %0d", c, bus.pred_ready_o, m_ready && q.size() < DEPTH);
      end
      pv  = ($urandom_range(9) < 6);
      rv  = ($urandom_range(9) < 4);
      idx = $urandom_range(3);
      g   = $urandom_range(1);
      l   = $urandom_range(1);
      t   = $urandom_range(1);
      drive_cycle(pv, idx, g, l, rv, t);
      tests_run += 4;
      if (bus.choice_v_o !== exp_choice_v) begin tests_failed++; $display("[TB] FAIL rand_choice_v_%0d: got %0d expected %0d", c, bus.choice_v_o, exp_choice_v); end
      if (int'(bus.choice_o) !== exp_choice) begin tests_failed++; $display("[TB] FAIL rand_choice_%0d: got %0d expected %0d", c, bus.choice_o, exp_choice); end
      if (int'(bus.fifo_count_o) !== exp_count) begin tests_failed++; $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", c, bus.fifo_count_o, exp_count); end
      if (bus.resolve_err_o !== exp_err) begin tests_failed++; $display("[TB] FAIL rand_err_%0d: got %0d expected %0d", c, bus.resolve_err_o, exp_err); end
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) drive_cycle(1, k, 1, 0, 0, 0);
    tests_run++;
    if (bus.fifo_count_o !== 3'd3) begin tests_failed++; $display("[TB] FAIL mid_count_before: got %0d expected 3", bus.fifo_count_o); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    tests_run += 2;
    if (bus.fifo_count_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_async_count: got %0d expected 0", bus.fifo_count_o); end
    if (bus.init_done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_async_done: got %0d expected 0", bus.init_done_o); end
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(0, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus.resolve_err_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_init_err: got %0d expected 1", bus.resolve_err_o); end
    for (int i = 1; i < ENTRIES; i++) drive_cycle(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.init_done_o !== 1'b1 || bus.fifo_count_o !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reinit: got done=%0d count=%0d expected 1/0", bus.init_done_o, bus.fifo_count_o);
    end
    for (int e = 0; e < ENTRIES; e++) begin
      drive_cycle(1, e, 0, 0, 0, 0);
      tests_run++;
      if (bus.choice_o !== 2'b01) begin tests_failed++; $display("[TB] FAIL mid_entry_%0d: got %0d expected 1", e, bus.choice_o); end
      drive_cycle(0, 0, 0, 0, 1, 0);
    end
  endtask

  initial begin
    bus.pred_v_i = 1'b0;
    bus.pred_idx_i = '0;
    bus.global_pred_i = 1'b0;
    bus.local_pred_i = 1'b0;
    bus.resolve_v_i = 1'b0;
    bus.taken_i = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_init_walk();
    test_increment_saturation();
    test_decrement();
    test_full_fifo();
    test_same_index();
    test_resolve_error();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
